// File: rtl/explosion_arbiter.sv
// Round-robin arbiter: latches one-cycle bomb requests per source and replays them as explosion strobes.
// Latency req->strobe 2 cycles, GAP+2 cycles between strobes; no backpressure, a re-request while pending is dropped and flagged.
module explosion_arbiter #(
    parameter int N_REQ = 4,
    parameter int GAP   = 2,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic                 sys_clk,
    input  logic                 Reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [10*N_REQ-1:0]  req_x,
    input  logic [10*N_REQ-1:0]  req_y,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     pending,
    output logic [N_REQ-1:0]     overflow,
    output logic [9:0]           e_x,
    output logic [9:0]           e_y,
    output logic                 explosion_SCEN,
    output logic [IW-1:0]        grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    state_t             state_q, state_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic [IW-1:0]      last_q, last_d;
    logic [N_REQ-1:0]   pending_q, pending_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [N_REQ-1:0]   overflow_q, overflow_d;
    logic               scen_q, scen_d;
    logic [9:0]         e_x_q, e_x_d;
    logic [9:0]         e_y_q, e_y_d;
    logic [IW-1:0]      grant_id_q, grant_id_d;
    logic [9:0]         slot_x_q [N_REQ];
    logic [9:0]         slot_x_d [N_REQ];
    logic [9:0]         slot_y_q [N_REQ];
    logic [9:0]         slot_y_d [N_REQ];

    logic [IW-1:0]      cand;
    logic [IW-1:0]      win_idx;
    logic               win_vld;

    // Search starts just after the last grant so the previous winner ranks lowest.
    always_comb begin
        cand    = '0;
        win_idx = last_q;
        win_vld = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(last_q) + k) % N_REQ);
            if (!win_vld && pending_q[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // ack_q marks the slot being issued this cycle, so a request then refills it instead of overflowing.
    always_comb begin
        pending_d  = pending_q & ~ack_q;
        overflow_d = '0;
        slot_x_d   = slot_x_q;
        slot_y_d   = slot_y_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i]) begin
                if (!pending_q[i] || ack_q[i]) begin
                    pending_d[i] = 1'b1;
                    slot_x_d[i]  = req_x[10*i +: 10];
                    slot_y_d[i]  = req_y[10*i +: 10];
                end else begin
                    overflow_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        last_d     = last_q;
        ack_d      = '0;
        scen_d     = 1'b0;
        e_x_d      = e_x_q;
        e_y_d      = e_y_q;
        grant_id_d = grant_id_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d        = ST_ISSUE;
                    scen_d         = 1'b1;
                    ack_d[win_idx] = 1'b1;
                    e_x_d          = slot_x_q[win_idx];
                    e_y_d          = slot_y_q[win_idx];
                    grant_id_d     = win_idx;
                    last_d         = win_idx;
                end
            end
            ST_ISSUE: begin
                gap_cnt_d = '0;
                state_d   = (GAP == 0) ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                gap_cnt_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            gap_cnt_q  <= '0;
            last_q     <= IW'(N_REQ - 1);
            pending_q  <= '0;
            ack_q      <= '0;
            overflow_q <= '0;
            scen_q     <= 1'b0;
            e_x_q      <= '0;
            e_y_q      <= '0;
            grant_id_q <= '0;
            slot_x_q   <= '{default: '0};
            slot_y_q   <= '{default: '0};
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            last_q     <= last_d;
            pending_q  <= pending_d;
            ack_q      <= ack_d;
            overflow_q <= overflow_d;
            scen_q     <= scen_d;
            e_x_q      <= e_x_d;
            e_y_q      <= e_y_d;
            grant_id_q <= grant_id_d;
            slot_x_q   <= slot_x_d;
            slot_y_q   <= slot_y_d;
        end
    end

    assign ack            = ack_q;
    assign pending        = pending_q;
    assign overflow       = overflow_q;
    assign e_x            = e_x_q;
    assign e_y            = e_y_q;
    assign explosion_SCEN = scen_q;
    assign grant_id       = grant_id_q;

endmodule

// File: doc/explosion_arbiter.md
# explosion_arbiter

Round-robin arbiter that shares the single explosion-event port (`e_x`, `e_y`, `explosion_SCEN`) between several bomb sources. Each source posts a one-cycle request carrying a tile coordinate. The arbiter latches it, then replays the requests one at a time as single-cycle strobes, spaced by a guaranteed idle gap. It sits between the bomb units and the consumers of explosion events: box walls, enemies and explosion rendering. Those consumers can each accept only one event per strobe.

## Interface
- `N_REQ`, 4: number of requesters; allowed range 2..8.
- `GAP`, 2: minimum idle cycles between consecutive `explosion_SCEN` pulses; allowed range 0..15.
- `IW`: derived, $clog2(`N_REQ`).
- `sys_clk` in 1: system clock, 100 MHz.
- `Reset` in 1: asynchronous, active-high reset.
- `req` in `N_REQ`: one-cycle request pulse per requester.
- `req_x` in 10*`N_REQ`: packed x coordinates; requester i uses bits [10i+9:10i].
- `req_y` in 10*`N_REQ`: packed y coordinates, same packing as `req_x`.
- `ack` out `N_REQ`: one-cycle pulse to requester i when its event is issued.
- `pending` out `N_REQ`: per-requester latched-request flags.
- `overflow` out `N_REQ`: one-cycle pulse when requester i's new request was dropped.
- `e_x` out 10: x coordinate of the issued event.
- `e_y` out 10: y coordinate of the issued event.
- `explosion_SCEN` out 1: one-cycle event strobe.
- `grant_id` out `IW`: index of the requester issued with the current or last strobe.

## Operation
- **Capture:** `req[i]` sampled high with `pending[i]`=0 sets `pending[i]` and latches `req_x`/`req_y` slice i into the internal slot i.
- **Overflow:** `req[i]` high while `pending[i]`=1 and slot i is not being acked in the same cycle:
  - the request is dropped;
  - the slot keeps its old coordinates;
  - `overflow[i]` pulses for 1 cycle.
- **Same-cycle ack and request:** `req[i]` in the same cycle as `ack[i]` counts as a new request. `pending[i]` stays 1 with the new coordinates, and no overflow is flagged.
- **FSM states:** IDLE, ISSUE, WAIT.
  - **IDLE:** if `pending` is nonzero, select the winner and go to ISSUE. Otherwise stay in IDLE.
  - **ISSUE (1 cycle):**
    - `explosion_SCEN`=1;
    - `e_x`/`e_y` = winner slot;
    - `grant_id` = winner;
    - `ack[winner]`=1;
    - `pending[winner]` cleared, unless set again per the same-cycle rule above;
    - `last` = winner.
    - Next state is WAIT if `GAP`>0, else IDLE.
  - **WAIT:** count `GAP` cycles, then return to IDLE. Requests are still captured during WAIT.
- **Round-robin order:** the winner is the first set bit of `pending`, searching from `last`+1 upward and wrapping mod `N_REQ`.
  - `last` resets to `N_REQ`-1, so requester 0 has first priority after reset.
  - A requester just granted has lowest priority for the next grant.
- **Output holding:** `e_x`, `e_y` and `grant_id` are registered and hold their last issued values between strobes, because downstream logic may compare against them.
- **Selection timing:** winner selection uses the `pending` value registered at the previous edge. A request captured at edge k is eligible at the IDLE decision made at edge k+1.

## Timing
- **Reset values:**
  - `ack`, `pending`, `overflow`, `explosion_SCEN` = 0;
  - `e_x`, `e_y` = 0;
  - `grant_id` = 0;
  - state = IDLE, gap counter = 0, `last` = `N_REQ`-1.
- **Reset mid-operation:** `Reset` asserted at any time clears all pending requests, with no strobe issued for them. A strobe in flight ends immediately.
- **Latency:** `req` is high in cycle 0 with the arbiter idle and nothing pending. `pending` is high in cycle 1, the IDLE decision is made in cycle 1, and `explosion_SCEN`/`ack` are high in cycle 2.
- **Throughput:** one strobe every `GAP`+2 cycles per busy arbiter. This is every 2 cycles when `GAP`=0, because IDLE is always visited.
- **Output registration:** all outputs are registered, with no combinational path from `req` to any output.
- **Coordinate arithmetic:** none; coordinates pass through unchanged at 10 bits.

## Test plan
- **Single request:**
  - Stimulus: after reset, `req`=0001 with x=207, y=98 in cycle 0.
  - Response: `pending[0]`=1 in cycle 1. In cycle 2, `explosion_SCEN`=1, `ack`=0001, `e_x`=207, `e_y`=98, `grant_id`=0.
  - Afterwards `e_x`/`e_y` hold 207/98.
- **Simultaneous requests:**
  - Stimulus: `req`=1111 in one cycle, x=i*16+143, `GAP`=2.
  - Response: strobes on ids 0,1,2,3, spaced 4 cycles apart, with `e_x`=143,159,175,191.
- **Round-robin fairness:**
  - Stimulus: requester 0 re-requests each time it is acked; requester 2 requests once.
  - Response: grants alternate 0,2,0,0; requester 2 is never starved past one grant.
- **Overflow:**
  - Stimulus: `req[1]` at x=300, then `req[1]` again at x=400 while still pending.
  - Response: `overflow`=0010 for 1 cycle, and the issued `e_x` is 300.
- **Ack/request collision:**
  - Stimulus: `req[0]` with x=500 in the same cycle as `ack[0]`.
  - Response: no overflow, and a second strobe with `e_x`=500 follows after the gap.
- **Reset mid-operation:**
  - Stimulus: 3 requests pending; `Reset` pulses during WAIT.
  - Response: all outputs are 0, and no strobe occurs until the next `req`. The next grant goes to requester 0 first.
